// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - grid geometry, game state encodings and paddle helpers for the pong controller
package pong_pkg;

    localparam int GRID_W      = 20;
    localparam int GRID_H      = 15;
    localparam int PADDLE_SIZE = 4;
    localparam int PADDLE_MAX  = 10;
    localparam int CENTRE_X    = 10;
    localparam int CENTRE_Y    = 7;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] POINT = 2'd2;
    localparam logic [1:0] OVER  = 2'd3;

    function automatic logic [3:0] paddle_step(input logic [3:0] pos, input logic up, input logic down);
        logic [3:0] res;
        res = pos;
        if (up && !down) begin
            res = (pos == 4'd0) ? pos : pos - 4'd1;
        end else if (down && !up) begin
            res = (pos >= 4'(PADDLE_MAX)) ? 4'(PADDLE_MAX) : pos + 4'd1;
        end
        return res;
    endfunction

    // Paddle covers rows pos..pos+PADDLE_SIZE inclusive.
    function automatic logic paddle_hit(input logic [3:0] pos, input logic [3:0] y);
        logic [4:0] top;
        logic [4:0] bot;
        top = {1'b0, pos};
        bot = top + 5'(PADDLE_SIZE);
        return ({1'b0, y} >= top) && ({1'b0, y} <= bot);
    endfunction

    // Computer paddle chases so that its middle row (pos+2) lines up with the ball.
    function automatic logic [3:0] ai_step(input logic [3:0] pos, input logic [3:0] y);
        logic [4:0] mid;
        logic [3:0] res;
        mid = {1'b0, pos} + 5'd2;
        res = pos;
        if (mid < {1'b0, y}) begin
            res = (pos >= 4'(PADDLE_MAX)) ? 4'(PADDLE_MAX) : pos + 4'd1;
        end else if (mid > {1'b0, y}) begin
            res = (pos == 4'd0) ? pos : pos - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// rtl/game_tick_gen.sv - free-running divider producing a one-cycle game tick strobe
module game_tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: ball, paddles, scores, state; COM_AI_EN selects computer paddle
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 2500000,
    parameter int PAUSE_TICKS = 10,
    parameter int WIN_SCORE   = 7
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnStart,
    input  logic       comUp,
    input  logic       comDown,
    output logic [4:0] ballX,
    output logic [3:0] ballY,
    output logic [3:0] playerPos,
    output logic [3:0] comPos,
    output logic [3:0] scorePlayer,
    output logic [3:0] scoreCom,
    output logic [1:0] gameState,
    output logic       tick
);

    localparam int PC_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic            dir_x, dir_y;
    logic [PC_W-1:0] pause_cnt;

    logic [4:0]      ball_x_n;
    logic [3:0]      ball_y_n, player_n, com_n, score_p_n, score_c_n;
    logic [3:0]      player_step, com_play, com_idle;
    logic [1:0]      state_n;
    logic            dir_x_n, dir_y_n;
    logic [PC_W-1:0] pause_n;

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (CLK_IN),
        .resetn (RST_N),
        .tick   (tick)
    );

    assign player_step = paddle_step(playerPos, btnUp, btnDown);

`ifdef COM_AI_EN
    logic unused_com;
    assign unused_com = comUp ^ comDown;
    assign com_play   = ai_step(comPos, ballY);
    assign com_idle   = comPos;
`else
    assign com_play   = paddle_step(comPos, comUp, comDown);
    assign com_idle   = com_play;
`endif

    always_comb begin
        ball_x_n  = ballX;
        ball_y_n  = ballY;
        player_n  = playerPos;
        com_n     = comPos;
        score_p_n = scorePlayer;
        score_c_n = scoreCom;
        state_n   = gameState;
        dir_x_n   = dir_x;
        dir_y_n   = dir_y;
        pause_n   = pause_cnt;
        case (gameState)
            IDLE: begin
                player_n = player_step;
                com_n    = com_idle;
                ball_x_n = 5'(CENTRE_X);
                ball_y_n = 4'(CENTRE_Y);
                if (btnStart) state_n = PLAY;
            end
            PLAY: begin
                player_n = player_step;
                com_n    = com_play;
                // dir bits: 1 = increasing coordinate
                if ((ballY == 4'd0 && !dir_y) || (ballY == 4'(GRID_H - 1) && dir_y)) begin
                    dir_y_n  = ~dir_y;
                    ball_y_n = dir_y ? ballY - 4'd1 : ballY + 4'd1;
                end else begin
                    ball_y_n = dir_y ? ballY + 4'd1 : ballY - 4'd1;
                end
                if (ballX == 5'd1 && !dir_x) begin
                    if (paddle_hit(playerPos, ballY)) begin
                        dir_x_n  = 1'b1;
                        ball_x_n = 5'd2;
                    end else begin
                        ball_x_n = 5'd0;
                        if (scoreCom != WIN) score_c_n = scoreCom + 4'd1;
                        state_n  = POINT;
                    end
                end else if (ballX == 5'(GRID_W - 2) && dir_x) begin
                    if (paddle_hit(comPos, ballY)) begin
                        dir_x_n  = 1'b0;
                        ball_x_n = 5'(GRID_W - 3);
                    end else begin
                        ball_x_n = 5'(GRID_W - 1);
                        if (scorePlayer != WIN) score_p_n = scorePlayer + 4'd1;
                        state_n  = POINT;
                    end
                end else begin
                    ball_x_n = dir_x ? ballX + 5'd1 : ballX - 5'd1;
                end
            end
            POINT: begin
                if (pause_cnt == PC_W'(PAUSE_TICKS - 1)) begin
                    pause_n = '0;
                    if (scorePlayer == WIN || scoreCom == WIN) begin
                        state_n = OVER;
                    end else begin
                        // serve toward whoever just lost the point
                        dir_x_n  = (ballX != 5'd0);
                        ball_x_n = 5'(CENTRE_X);
                        ball_y_n = 4'(CENTRE_Y);
                        state_n  = IDLE;
                    end
                end else begin
                    pause_n = pause_cnt + 1'b1;
                end
            end
            OVER: begin
                if (btnStart) begin
                    score_p_n = 4'd0;
                    score_c_n = 4'd0;
                    ball_x_n  = 5'(CENTRE_X);
                    ball_y_n  = 4'(CENTRE_Y);
                    player_n  = 4'd5;
                    com_n     = 4'd5;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            ballX       <= 5'(CENTRE_X);
            ballY       <= 4'(CENTRE_Y);
            playerPos   <= 4'd5;
            comPos      <= 4'd5;
            scorePlayer <= 4'd0;
            scoreCom    <= 4'd0;
            gameState   <= IDLE;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            pause_cnt   <= '0;
        end else if (tick) begin
            ballX       <= ball_x_n;
            ballY       <= ball_y_n;
            playerPos   <= player_n;
            comPos      <= com_n;
            scorePlayer <= score_p_n;
            scoreCom    <= score_c_n;
            gameState   <= state_n;
            dir_x       <= dir_x_n;
            dir_y       <= dir_y_n;
            pause_cnt   <= pause_n;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl with a per-cycle game model
module tb_pong_game_ctrl;

    localparam int TD = 4;
    localparam int PT = 2;
    localparam int WS = 2;

    logic       CLK_IN = 1'b0;
    logic       RST_N = 1'b0;
    logic       btnUp = 1'b0, btnDown = 1'b0, btnStart = 1'b0, comUp = 1'b0, comDown = 1'b0;
    logic [4:0] ballX;
    logic [3:0] ballY, playerPos, comPos, scorePlayer, scoreCom;
    logic [1:0] gameState;
    logic       tick;

    int n_checks = 0;
    int n_fail = 0;

    int m_bx, m_by, m_dx, m_dy, m_pp, m_cp, m_sp, m_sc, m_st, m_pause, m_div;
    bit model_ok = 1'b0;

    int up_tab[7] = '{4, 3, 2, 1, 0, 0, 0};
    int ai_tab[8] = '{5, 6, 7, 8, 9, 10, 10, 10};

    pong_game_ctrl #(.TICK_DIV(TD), .PAUSE_TICKS(PT), .WIN_SCORE(WS)) dut (
        .CLK_IN      (CLK_IN),
        .RST_N       (RST_N),
        .btnUp       (btnUp),
        .btnDown     (btnDown),
        .btnStart    (btnStart),
        .comUp       (comUp),
        .comDown     (comDown),
        .ballX       (ballX),
        .ballY       (ballY),
        .playerPos   (playerPos),
        .comPos      (comPos),
        .scorePlayer (scorePlayer),
        .scoreCom    (scoreCom),
        .gameState   (gameState),
        .tick        (tick)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pad_move(input int p, input bit u, input bit d);
        if (u && !d) return (p > 0) ? p - 1 : 0;
        if (d && !u) return (p < 10) ? p + 1 : 10;
        return p;
    endfunction

    function automatic bit covers(input int top, input int y);
        return (y >= top) && (y <= top + 4);
    endfunction

    function automatic int ai_move(input int p, input int y);
        int target;
        target = y - 2;
        if (p < target) return (p < 10) ? p + 1 : 10;
        if (p > target) return (p > 0) ? p - 1 : 0;
        return p;
    endfunction

    // One game tick of the rules, expressed as reflect-on-overflow arithmetic.
    task automatic model_tick();
        int py, opp, ocp, nx, ny;
        case (m_st)
            0: begin
                m_pp = pad_move(m_pp, btnUp, btnDown);
`ifndef COM_AI_EN
                m_cp = pad_move(m_cp, comUp, comDown);
`endif
                if (btnStart) m_st = 1;
            end
            1: begin
                py  = m_by;
                opp = m_pp;
                ocp = m_cp;
                m_pp = pad_move(opp, btnUp, btnDown);
`ifdef COM_AI_EN
                m_cp = ai_move(ocp, py);
`else
                m_cp = pad_move(ocp, comUp, comDown);
`endif
                ny = py + m_dy;
                if (ny < 0 || ny > 14) begin
                    m_dy = -m_dy;
                    ny = py + m_dy;
                end
                nx = m_bx + m_dx;
                if (nx == 0) begin
                    if (covers(opp, py)) begin m_dx = 1; nx = 2; end
                    else begin m_sc = (m_sc < WS) ? m_sc + 1 : WS; m_st = 2; end
                end else if (nx == 19) begin
                    if (covers(ocp, py)) begin m_dx = -1; nx = 17; end
                    else begin m_sp = (m_sp < WS) ? m_sp + 1 : WS; m_st = 2; end
                end
                m_bx = nx;
                m_by = ny;
            end
            2: begin
                m_pause++;
                if (m_pause == PT) begin
                    m_pause = 0;
                    if (m_sp == WS || m_sc == WS) m_st = 3;
                    else begin
                        m_dx = (m_bx == 0) ? -1 : 1;
                        m_bx = 10; m_by = 7; m_st = 0;
                    end
                end
            end
            default: begin
                if (btnStart) begin
                    m_sp = 0; m_sc = 0; m_bx = 10; m_by = 7; m_pp = 5; m_cp = 5; m_st = 0;
                end
            end
        endcase
    endtask

    always @(posedge CLK_IN) begin
        if (!RST_N) begin
            m_bx = 10; m_by = 7; m_dx = 1; m_dy = 1; m_pp = 5; m_cp = 5;
            m_sp = 0; m_sc = 0; m_st = 0; m_pause = 0; m_div = 0;
            model_ok = 1'b1;
        end else if (m_div == TD - 1) begin
            m_div = 0;
            model_tick();
        end else begin
            m_div++;
        end
    end

    always @(negedge CLK_IN) begin
        if (model_ok) begin
            chk("model_ballX", ballX, m_bx);
            chk("model_ballY", ballY, m_by);
            chk("model_playerPos", playerPos, m_pp);
            chk("model_comPos", comPos, m_cp);
            chk("model_scorePlayer", scorePlayer, m_sp);
            chk("model_scoreCom", scoreCom, m_sc);
            chk("model_gameState", gameState, m_st);
            chk("model_tick", tick, int'(m_div == TD - 1));
        end
    end

    task automatic do_tick();
        int n;
        n = 0;
        @(negedge CLK_IN);
        while (tick !== 1'b1 && n < 8) begin
            @(negedge CLK_IN);
            n++;
        end
        if (tick !== 1'b1) chk("tick_wait", 0, 1);
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic run_to_point(output int ticks);
        ticks = 0;
        while (gameState == 2'd1 && ticks < 100) begin
            do_tick();
            ticks++;
        end
    endtask

    task automatic chk_ball(input string name, input int x, input int y);
        chk({name, "_x"}, ballX, x);
        chk({name, "_y"}, ballY, y);
    endtask

    task automatic chk_reset_vals(input string name);
        chk_ball(name, 10, 7);
        chk({name, "_pp"}, playerPos, 5);
        chk({name, "_cp"}, comPos, 5);
        chk({name, "_sp"}, scorePlayer, 0);
        chk({name, "_sc"}, scoreCom, 0);
        chk({name, "_state"}, gameState, 0);
        chk({name, "_tick"}, tick, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge CLK_IN);
        #1;
        chk_reset_vals("reset");
        @(negedge CLK_IN);
        RST_N = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge CLK_IN);
            if (tick) n++;
        end
        chk("tick_rate", n, 3);
        chk_ball("idle_hold", 10, 7);
        chk("idle_state", gameState, 0);

`ifdef COM_AI_EN
        btnStart = 1'b1;
        do_tick();
        btnStart = 1'b0;
        chk("serve_state", gameState, 1);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            chk("ai_comPos", comPos, ai_tab[k-1]);
            if (k == 5) chk("ai_ballY", ballY, 12);
        end
`else
        btnStart = 1'b1;
        do_tick();
        chk("serve_state", gameState, 1);
        chk_ball("serve_ball", 10, 7);
        btnStart = 1'b0;
        btnUp = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            do_tick();
            chk("pp_up", playerPos, up_tab[k-1]);
            chk_ball("path", 10 + k, 7 + k);
        end
        btnUp = 1'b0; btnDown = 1'b1;
        do_tick();
        chk("pp_down", playerPos, 1);
        chk_ball("bounce_bottom", 18, 13);
        btnUp = 1'b1;
        do_tick();
        chk("pp_both_hold", playerPos, 1);
        chk_ball("right_miss", 19, 12);
        chk("right_miss_sp", scorePlayer, 1);
        chk("right_miss_sc", scoreCom, 0);
        chk("right_miss_state", gameState, 2);
        btnUp = 1'b0; btnDown = 1'b0;
        do_tick();
        chk("pause1_state", gameState, 2);
        chk("pause1_ballX", ballX, 19);
        do_tick();
        chk("pause_end_state", gameState, 0);
        chk_ball("pause_end", 10, 7);

        btnStart = 1'b1; comUp = 1'b1;
        do_tick();
        chk("serve2_state", gameState, 1);
        chk("serve2_cp", comPos, 4);
        btnStart = 1'b0; btnDown = 1'b1;
        do_tick();
        chk_ball("serve2_dir", 11, 6);
        repeat (4) do_tick();
        chk("pp_to6", playerPos, 6);
        chk("cp_to0", comPos, 0);
        chk_ball("rally_t5", 15, 2);
        comUp = 1'b0; btnDown = 1'b0;
        repeat (4) do_tick();
        chk_ball("com_hit", 17, 2);
        chk("com_hit_state", gameState, 1);
        repeat (16) do_tick();
        chk_ball("rally_t25", 1, 10);
        do_tick();
        chk_ball("player_hit", 2, 9);
        chk("player_hit_sp", scorePlayer, 1);
        chk("player_hit_sc", scoreCom, 0);
        chk("player_hit_state", gameState, 1);
        comDown = 1'b1;
        repeat (5) do_tick();
        chk("cp_to5", comPos, 5);
        comDown = 1'b0;
        run_to_point(n);
        chk("rally2_len", n, 29);
        chk_ball("left_miss", 0, 3);
        chk("left_miss_state", gameState, 2);
        chk("left_miss_sc", scoreCom, 1);
        chk("left_miss_sp", scorePlayer, 1);
        repeat (2) do_tick();
        chk("pause2_state", gameState, 0);
        chk_ball("pause2", 10, 7);
        btnStart = 1'b1;
        do_tick();
        btnStart = 1'b0;
        do_tick();
        chk_ball("serve_left", 9, 6);

        run_to_point(n);
        chk("rally3_len", n, 9);
        chk_ball("left_miss2", 0, 3);
        chk("left_miss2_sc", scoreCom, 2);
        repeat (2) do_tick();
        chk("over_state", gameState, 3);
        chk("over_sp", scorePlayer, 1);
        chk("over_sc", scoreCom, 2);
        btnUp = 1'b1;
        do_tick();
        chk("over_frozen_pp", playerPos, 6);
        chk("over_hold_state", gameState, 3);
        btnUp = 1'b0; btnStart = 1'b1;
        do_tick();
        btnStart = 1'b0;
        chk_reset_vals("restart");
`endif

        btnStart = 1'b1;
        do_tick();
        btnStart = 1'b0;
        repeat (3) do_tick();
        chk("pre_reset_state", gameState, 1);
        n = 0;
        @(negedge CLK_IN);
        while (tick !== 1'b1 && n < 8) begin
            @(negedge CLK_IN);
            n++;
        end
        chk("mid_tick_found", tick, 1);
        RST_N = 1'b0;
        @(posedge CLK_IN);
        #1;
        chk_reset_vals("mid_reset");
        @(negedge CLK_IN);
        RST_N = 1'b1;
        repeat (8) @(negedge CLK_IN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
